// File: rtl/seq_borrow_lookahead_subtractor_pkg.sv
// Shared definitions for the sliced borrow-lookahead subtractor:
// FSM state encoding and slice-count helpers used to size the slice index.
package seq_borrow_lookahead_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_N     = 8;
    localparam int DEF_CHUNK = 4;

    function automatic int slice_count(input int n, input int chunk);
        return n / chunk;
    endfunction

    // A single-slice build still needs a 1-bit index register.
    function automatic int idx_width(input int nslice);
        return (nslice <= 1) ? 1 : $clog2(nslice);
    endfunction

endpackage

// File: rtl/seq_borrow_lookahead_subtractor_slice.sv
// Combinational CHUNK-bit borrow-lookahead slice: every internal borrow is a
// flat sum of generate/propagate products, so no borrow ripples through bits.
module borrow_lookahead_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             bin,
    output logic [CHUNK-1:0] d,
    output logic             bout
);

    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic [CHUNK:0]   br;
    logic             term;
    logic             acc;

    always_comb begin
        g    = ~a & b;
        p    = ~(a ^ b);
        br   = '0;
        term = 1'b0;
        acc  = 1'b0;
        br[0] = bin;
        // br[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]bin, expanded term by term
        for (int i = 0; i < CHUNK; i++) begin
            term = bin;
            for (int j = 0; j <= i; j++) begin
                term = term & p[j];
            end
            acc = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                acc = acc | term;
            end
            br[i+1] = acc;
        end
        d    = a ^ b ^ br[CHUNK-1:0];
        bout = br[CHUNK];
    end

endmodule

// File: rtl/seq_borrow_lookahead_subtractor.sv
// Multi-cycle unsigned subtractor D = A - B - Bin, one CHUNK-bit slice per clock,
// LSB first, borrow carried between slices in a register.
module seq_borrow_lookahead_subtractor
    import seq_borrow_lookahead_subtractor_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] D,
    output logic         Bout,
    output logic [1:0]   state_dbg
);

    localparam int NSLICE = slice_count(N, CHUNK);
    localparam int IDXW   = idx_width(NSLICE);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    if ((N % CHUNK) != 0) begin : g_bad_width
        $error("N must be a multiple of CHUNK");
    end

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high. in_ready is high only in IDLE, out_valid only in DONE, so
    // in_valid is ignored while busy and the result stays put until taken.

    state_t state;
    state_t state_next;

    logic [N-1:0]     a_reg;
    logic [N-1:0]     b_reg;
    logic [N-1:0]     d_reg;
    logic [N-1:0]     d_next;
    logic             borrow_reg;
    logic             bout_reg;
    logic [IDXW-1:0]  idx;

    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic [CHUNK-1:0] slice_d;
    logic             slice_bout;
    logic             accept;
    logic             last_slice;

    borrow_lookahead_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .bin  (borrow_reg),
        .d    (slice_d),
        .bout (slice_bout)
    );

    always_comb begin
        slice_a = a_reg[int'(idx)*CHUNK +: CHUNK];
        slice_b = b_reg[int'(idx)*CHUNK +: CHUNK];
        d_next  = d_reg;
        d_next[int'(idx)*CHUNK +: CHUNK] = slice_d;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        last_slice = (idx == LAST_IDX);
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_slice) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            d_reg      <= '0;
            borrow_reg <= 1'b0;
            bout_reg   <= 1'b0;
            idx        <= '0;
        end else begin
            if (accept) begin
                a_reg      <= A;
                b_reg      <= B;
                borrow_reg <= Bin;
                idx        <= '0;
            end else if (state == ST_RUN) begin
                d_reg      <= d_next;
                borrow_reg <= slice_bout;
                idx        <= idx + 1'b1;
                if (last_slice) begin
                    bout_reg <= slice_bout;
                end
            end
        end
    end

    assign D         = d_reg;
    assign Bout      = bout_reg;
    assign state_dbg = state;

endmodule

// File: tb/tb_seq_borrow_lookahead_subtractor.sv
// Self-checking bench: directed cases, backpressure, reset abort, random 8/4
// vectors and exhaustive 4/2 and 4/4 sweeps against an integer reference model.
module tb_seq_borrow_lookahead_subtractor;
    import seq_borrow_lookahead_subtractor_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // instance 0: N=8 CHUNK=4
    logic       iv0 = 1'b0, ir0, ov0, or0 = 1'b0, bin0 = 1'b0, bo0;
    logic [7:0] a0 = '0, b0 = '0, d0;
    logic [1:0] st0;
    // instance 1: N=4 CHUNK=2
    logic       iv1 = 1'b0, ir1, ov1, or1 = 1'b0, bin1 = 1'b0, bo1;
    logic [3:0] a1 = '0, b1 = '0, d1;
    logic [1:0] st1;
    // instance 2: N=4 CHUNK=4 (single-cycle compute)
    logic       iv2 = 1'b0, ir2, ov2, or2 = 1'b0, bin2 = 1'b0, bo2;
    logic [3:0] a2 = '0, b2 = '0, d2;
    logic [1:0] st2;

    seq_borrow_lookahead_subtractor #(.N(8), .CHUNK(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .A(a0), .B(b0),
        .Bin(bin0), .out_valid(ov0), .out_ready(or0), .D(d0), .Bout(bo0), .state_dbg(st0));
    seq_borrow_lookahead_subtractor #(.N(4), .CHUNK(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1),
        .Bin(bin1), .out_valid(ov1), .out_ready(or1), .D(d1), .Bout(bo1), .state_dbg(st1));
    seq_borrow_lookahead_subtractor #(.N(4), .CHUNK(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .A(a2), .B(b2),
        .Bin(bin2), .out_valid(ov2), .out_ready(or2), .D(d2), .Bout(bo2), .state_dbg(st2));

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] exp_q[$];
    logic [7:0] last_d;
    logic       last_bout;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input int inst, input logic v, input logic [7:0] a,
                             input logic [7:0] b, input logic bin);
        case (inst)
            0:       begin iv0 = v; a0 = a;      b0 = b;      bin0 = bin; end
            1:       begin iv1 = v; a1 = a[3:0]; b1 = b[3:0]; bin1 = bin; end
            default: begin iv2 = v; a2 = a[3:0]; b2 = b[3:0]; bin2 = bin; end
        endcase
    endtask

    task automatic drive_ordy(input int inst, input logic v);
        case (inst)
            0:       or0 = v;
            1:       or1 = v;
            default: or2 = v;
        endcase
    endtask

    function automatic logic get_ov(input int inst);
        case (inst)
            0:       return ov0;
            1:       return ov1;
            default: return ov2;
        endcase
    endfunction

    function automatic logic get_ir(input int inst);
        case (inst)
            0:       return ir0;
            1:       return ir1;
            default: return ir2;
        endcase
    endfunction

    function automatic logic [8:0] get_res(input int inst);
        case (inst)
            0:       return {bo0, d0};
            1:       return {bo1, 4'h0, d1};
            default: return {bo2, 4'h0, d2};
        endcase
    endfunction

    // One full request/result handshake; lat counts edges from accept to out_valid.
    task automatic do_txn(input int inst, input logic [7:0] a, input logic [7:0] b,
                          input logic bin, output logic [8:0] res, output int lat);
        @(negedge clk);
        check("idle_in_ready", 32'(get_ir(inst)), 32'd1);
        drive_req(inst, 1'b1, a, b, bin);
        @(posedge clk);
        #1;
        drive_req(inst, 1'b0, ~a, ~b, ~bin);
        lat = 0;
        while (!get_ov(inst) && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = get_res(inst);
        drive_ordy(inst, 1'b1);
        @(posedge clk);
        #1;
        drive_ordy(inst, 1'b0);
    endtask

    task automatic run_vec(input int inst, input logic [7:0] a_in, input logic [7:0] b_in,
                           input logic bin, input string tag);
        logic [7:0] mask;
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] exp;
        logic [8:0] res;
        int diff;
        int lat;
        int lat_exp;
        mask    = (inst == 0) ? 8'hFF : 8'h0F;
        lat_exp = (inst == 2) ? 1 : 2;
        a       = a_in & mask;
        b       = b_in & mask;
        diff    = int'(a) - int'(b) - int'(bin);
        exp     = {1'b0, 8'(diff) & mask};
        exp[8]  = (diff < 0);
        exp_q.push_back(exp);
        do_txn(inst, a, b, bin, res, lat);
        check({tag, "_result"}, 32'(res), 32'(exp_q.pop_front()));
        check({tag, "_latency"}, 32'(lat), 32'(lat_exp));
        last_d    = res[7:0];
        last_bout = res[8];
    endtask

    task automatic directed(input logic [7:0] a, input logic [7:0] b, input logic bin,
                            input logic [7:0] exp_d, input logic exp_bout, input string tag);
        run_vec(0, a, b, bin, tag);
        check({tag, "_d"}, 32'(last_d), 32'(exp_d));
        check({tag, "_bout"}, 32'(last_bout), 32'(exp_bout));
    endtask

    initial begin
        int wait_cnt;

        #2;
        check("reset_in_ready", 32'(ir0), 32'd1);
        check("reset_out_valid", 32'(ov0), 32'd0);
        check("reset_d", 32'(d0), 32'd0);
        check("reset_bout", 32'(bo0), 32'd0);
        check("reset_state", 32'(st0), 32'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;

        directed(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, "t1_basic");
        directed(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, "t2_underflow");
        directed(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, "t2_interslice");
        directed(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "t3_bin_wrap");
        directed(8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, "t3_mixed");

        // backpressure: result held for 5 cycles while in_valid pulses
        @(negedge clk);
        drive_req(0, 1'b1, 8'h37, 8'h12, 1'b0);
        @(posedge clk);
        #1;
        drive_req(0, 1'b0, 8'h00, 8'h00, 1'b0);
        check("bp_no_partial_valid", 32'(ov0), 32'd0);
        wait_cnt = 0;
        while (!ov0 && wait_cnt < 20) begin
            @(posedge clk);
            #1;
            wait_cnt++;
        end
        check("bp_latency", 32'(wait_cnt), 32'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive_req(0, (i % 2) == 0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
            @(posedge clk);
            #1;
            check("bp_d_held", 32'(d0), 32'h25);
            check("bp_bout_held", 32'(bo0), 32'd0);
            check("bp_out_valid", 32'(ov0), 32'd1);
            check("bp_in_ready", 32'(ir0), 32'd0);
        end
        // in_valid and out_ready together in DONE: only the result handshake counts
        @(negedge clk);
        drive_req(0, 1'b1, 8'hFF, 8'h00, 1'b0);
        or0 = 1'b1;
        @(posedge clk);
        #1;
        drive_req(0, 1'b0, 8'h00, 8'h00, 1'b0);
        or0 = 1'b0;
        check("bp_release_out_valid", 32'(ov0), 32'd0);
        check("bp_release_in_ready", 32'(ir0), 32'd1);
        check("bp_release_d", 32'(d0), 32'h25);
        @(posedge clk);
        #1;
        check("bp_no_accept_in_done", 32'(st0), 32'(ST_IDLE));

        // reset abort one cycle after accept
        @(negedge clk);
        drive_req(0, 1'b1, 8'h37, 8'h12, 1'b0);
        @(posedge clk);
        #1;
        drive_req(0, 1'b0, 8'h00, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        check("abort_partial_d", 32'(d0[3:0]), 32'h5);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(ir0), 32'd1);
        check("abort_out_valid", 32'(ov0), 32'd0);
        check("abort_d", 32'(d0), 32'd0);
        check("abort_bout", 32'(bo0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        directed(8'h37, 8'h12, 1'b0, 8'h25, 1'b0, "t5_after_abort");

        for (int i = 0; i < 2000; i++) begin
            run_vec(0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)), "rand_n8c4");
        end

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    run_vec(1, 8'(a), 8'(b), 1'(c), "exh_n4c2");
                    run_vec(2, 8'(a), 8'(b), 1'(c), "exh_n4c4");
                end
            end
        end

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
